// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants: S-box table, round count and the bit permutation.
package present_pkg;

  localparam int unsigned PRESENT_ROUNDS = 31;

  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] p;
    p = '0;
    for (int unsigned i = 0; i < 63; i++) begin
      p[6'((16 * i) % 63)] = s[6'(i)];
    end
    p[63] = s[63];
    return p;
  endfunction

endpackage

// File: rtl/present_sbox.sv
// Single 4-bit PRESENT S-box, purely combinational.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = PRESENT_SBOX[x];

endmodule

// File: rtl/present_cyt.sv
// Iterative PRESENT-80 encryptor: one round per clock, final key whitening on edge 32.
module present_cyt
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic [63:0] cyphertext
);

  logic [63:0] state;
  logic [79:0] kreg;
  logic [5:0]  rnd;

  logic [63:0] mixed;
  logic [63:0] subbed;
  logic [63:0] state_next;
  logic [79:0] krot;
  logic [3:0]  ktop;
  logic [79:0] kreg_next;
  logic        in_round;

  assign mixed = state ^ kreg[79:16];

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    present_sbox u_sbox (
      .x (mixed[4*n +: 4]),
      .y (subbed[4*n +: 4])
    );
  end

  assign state_next = p_layer(subbed);

  assign krot = {kreg[18:0], kreg[79:19]};

  present_sbox u_ksbox (
    .x (krot[79:76]),
    .y (ktop)
  );

  assign kreg_next = {ktop, krot[75:20], krot[19:15] ^ rnd[4:0], krot[14:0]};

  assign in_round = (rnd >= 6'd1) && (rnd <= 6'(PRESENT_ROUNDS));

  // rnd==33 is the idle state: no branch fires, so every register holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= plaintext;
      kreg       <= key;
      rnd        <= 6'd1;
      cyphertext <= '0;
    end else if (in_round) begin
      state <= state_next;
      kreg  <= kreg_next;
      rnd   <= rnd + 6'd1;
    end else if (rnd == 6'(PRESENT_ROUNDS + 1)) begin
      cyphertext <= mixed;
      rnd        <= rnd + 6'd1;
    end
  end

endmodule

// File: tb/tb_present_cyt.sv
// Self-checking bench for present_cyt: known-answer table, hold/abort sequences, random vs model.
module tb_present_cyt;

  logic        clk;
  logic        reset;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic [63:0] cyphertext;

  int n_err;
  int n_chk;

  present_cyt dut (
    .clk        (clk),
    .reset      (reset),
    .plaintext  (plaintext),
    .key        (key),
    .cyphertext (cyphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } vec_t;

  vec_t vecs [4];

  // Straight software PRESENT-80 from the algorithm description.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k_in);
    logic [3:0]  sb [16];
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s = pt;
    k = k_in;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sb[s[4*j +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) begin
        if (i == 63) t[63] = s[63];
        else         t[(16 * i) % 63] = s[i];
      end
      s = t;
      k = (k << 61) | (k >> 19);
      k[79:76] = sb[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load for two edges, release, check the output is still 0 at edge 31 and the result at edge 32.
  task automatic run(input string tag, input logic [63:0] pt, input logic [79:0] k,
                     input logic [63:0] exp, input bit check_zero);
    @(negedge clk);
    reset = 1'b0;
    plaintext = pt;
    key = k;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_reset_zero"}, cyphertext, 64'h0);
    reset = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    if (check_zero) check({tag, "_edge31_zero"}, cyphertext, 64'h0);
    @(posedge clk);
    #1;
    check({tag, "_edge32"}, cyphertext, exp);
  endtask

  initial begin
    logic [63:0] rpt;
    logic [79:0] rkey;

    n_err = 0;
    n_chk = 0;
    reset = 1'b0;
    plaintext = '0;
    key = '0;

    vecs[0] = '{pt: 64'h0000000000000000, key: 80'h0,                     ct: 64'h5579C1387B228445};
    vecs[1] = '{pt: 64'h0000000000000000, key: 80'hFFFFFFFFFFFFFFFFFFFF,  ct: 64'hE72C46C0F5945049};
    vecs[2] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'h0,                     ct: 64'hA112FFC72F68417B};
    vecs[3] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'hFFFFFFFFFFFFFFFFFFFF,  ct: 64'h3333DCD3213210D2};

    for (int v = 0; v < 4; v++) begin
      run($sformatf("kat%0d", v), vecs[v].pt, vecs[v].key, vecs[v].ct, 1'b1);
    end

    // Inputs changed after completion must not disturb the held result.
    @(negedge clk);
    plaintext = 64'h0123456789ABCDEF;
    key = 80'h13579BDF02468ACE1357;
    repeat (8) @(negedge clk);
    check("hold_after_done", cyphertext, 64'h3333DCD3213210D2);

    // Inputs changed mid-run are ignored too.
    @(negedge clk);
    reset = 1'b0;
    plaintext = 64'h0;
    key = 80'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    plaintext = 64'hFFFFFFFFFFFFFFFF;
    key = 80'hFFFFFFFFFFFFFFFFFFFF;
    repeat (27) @(posedge clk);
    #1;
    check("midrun_input_ignored", cyphertext, 64'h5579C1387B228445);

    // Abort: start vector 0, reset lands on edge 10, load vector 1, fresh run.
    @(negedge clk);
    reset = 1'b0;
    plaintext = 64'h0;
    key = 80'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    plaintext = 64'h0;
    key = 80'hFFFFFFFFFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    check("abort_clears", cyphertext, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      if (cyphertext !== 64'h0) begin
        check($sformatf("abort_run_zero_e%0d", e), cyphertext, 64'h0);
      end
    end
    n_chk++;
    @(posedge clk);
    #1;
    check("abort_result", cyphertext, 64'hE72C46C0F5945049);

    run("rand_fixed", 64'h834349FD8E99A23B, 80'h0, ref_enc(64'h834349FD8E99A23B, 80'h0), 1'b1);

    for (int n = 0; n < 100; n++) begin
      rpt  = {$urandom, $urandom};
      rkey = {16'($urandom), $urandom, $urandom};
      run($sformatf("rand%0d", n), rpt, rkey, ref_enc(rpt, rkey), (n % 10) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
